// File: rtl/stack_ext.sv
// stack_ext: parametrised LIFO with count, threshold flags, sticky error flags, clear and replace-top
module stack_ext #(
  parameter int B = 8,
  parameter int W = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);
  logic [B-1:0] mem [2**W];
  logic [W-1:0] top;
  logic         do_push, do_pop, do_repl;
  assign top          = count[W-1:0] - 1'b1;
  assign full         = count == (W+1)'(2**W);
  assign empty        = count == '0;
  assign almost_full  = count >= (W+1)'(AF_LEVEL);
  assign almost_empty = count <= (W+1)'(AE_LEVEL);
  assign r_data       = empty ? '0 : mem[top];
  // push+pop on an empty stack degenerates to a plain push
  assign do_push = push & (~pop | empty) & ~full;
  assign do_repl = push & pop & ~empty;
  assign do_pop  = pop & ~push & ~empty;
  always_ff @(posedge clk)
    if (do_push | do_repl) mem[do_repl ? top : count[W-1:0]] <= w_data;
  always_ff @(posedge clk) begin
    if (reset | clear) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= do_push ? count + 1'b1 : do_pop ? count - 1'b1 : count;
      overflow  <= overflow | (push & ~pop & full);
      underflow <= underflow | (pop & ~push & empty);
    end
  end
endmodule

// File: tb/tb_stack_ext.sv
// tb_stack_ext: directed + random scoreboard bench for stack_ext
module tb_stack_ext;
  logic       clk = 0, reset = 1, clear = 0, push = 0, pop = 0;
  logic [7:0] w_data = 0, r_data;
  logic [4:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] m [16];
  int         n = 0;
  bit         ov = 0, un = 0;
  logic [18:0] sb [$];

  stack_ext dut (.clk(clk), .reset(reset), .clear(clear), .push(push), .pop(pop),
    .w_data(w_data), .r_data(r_data), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] model_vec();
    logic [7:0] rd;
    rd = (n == 0) ? 8'h00 : m[n-1];
    return {rd, 5'(n), n == 16, n == 0, n >= 14, n <= 2, ov, un};
  endfunction

  task automatic step(input logic rs, input logic cl, input logic pu, input logic po, input logic [7:0] d);
    @(negedge clk);
    reset = rs; clear = cl; push = pu; pop = po; w_data = d;
    if (rs || cl) begin
      n = 0; ov = 0; un = 0;
    end else if (pu && (!po || n == 0)) begin
      if (n < 16) begin m[n] = d; n++; end else ov = 1;
    end else if (pu && po) m[n-1] = d;
    else if (po) begin
      if (n > 0) n--; else un = 1;
    end
    sb.push_back(model_vec());
    @(posedge clk); #1;
    chk("state", {r_data, count, full, empty, almost_full, almost_empty, overflow, underflow}, sb.pop_front());
  endtask

  task automatic pu_(input logic [7:0] d); step(0, 0, 1, 0, d); endtask
  task automatic po_(); step(0, 0, 0, 1, 0); endtask
  task automatic cl_(); step(0, 1, 0, 0, 0); endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_count", count, 0); chk("rst_empty", empty, 1); chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0); chk("rst_af", almost_full, 0); chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0); chk("rst_rdata", r_data, 8'h00);
    pu_(8'hA5); pu_(8'h3C); pu_(8'h7E);
    chk("p3_count", count, 3); chk("p3_rdata", r_data, 8'h7E); chk("p3_ae", almost_empty, 0);
    po_(); po_();
    chk("pop2_count", count, 1); chk("pop2_rdata", r_data, 8'hA5); chk("pop2_empty", empty, 0);
    cl_();
    for (int i = 0; i < 16; i++) pu_(8'(i));
    chk("f_full", full, 1); chk("f_count", count, 16); chk("f_rdata", r_data, 8'h0F); chk("f_af", almost_full, 1);
    pu_(8'h99);
    chk("ovf_count", count, 16); chk("ovf_rdata", r_data, 8'h0F); chk("ovf_flag", overflow, 1);
    po_();
    chk("ovf_pop_full", full, 0); chk("ovf_sticky", overflow, 1); chk("ovf_pop_rdata", r_data, 8'h0E);
    cl_(); po_();
    chk("udf_flag", underflow, 1); chk("udf_count", count, 0);
    cl_();
    chk("clr_udf", underflow, 0); chk("clr_ovf", overflow, 0);
    pu_(8'hA5); pu_(8'h3C); pu_(8'h7E);
    step(0, 0, 1, 1, 8'h55);
    chk("repl_count", count, 3); chk("repl_rdata", r_data, 8'h55);
    cl_();
    step(0, 0, 1, 1, 8'h11);
    chk("pp_empty_count", count, 1); chk("pp_empty_rdata", r_data, 8'h11); chk("pp_empty_udf", underflow, 0);
    pu_(8'h22);
    chk("ae_at2", almost_empty, 1);
    pu_(8'h33);
    chk("ae_at3", almost_empty, 0);
    for (int i = 3; i < 13; i++) pu_(8'(i));
    chk("af_at13", almost_full, 0);
    pu_(8'hD0);
    chk("af_at14", almost_full, 1);
    cl_();
    for (int i = 0; i < 5; i++) pu_(8'(8'h40 + i));
    chk("mid_count5", count, 5);
    step(1, 0, 1, 0, 8'hEE);
    chk("mid_rst_count", count, 0); chk("mid_rst_rdata", r_data, 8'h00);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
